// File: rtl/caliptra_apb_initiator_if.sv
// Command, response and APB bus bundle for the Caliptra APB initiator.
// The master modport is the initiator's view. The slave modport is the view of
// whatever sits on the other side: the command source, the response sink and
// the APB completer.
interface caliptra_apb_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 32
);
  // Command stream
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [USER_W-1:0] req_user;

  // Response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB requester signals
  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [USER_W-1:0] pauser;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_user,
    input  rsp_ready,
    input  prdata, pready, pslverr,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output paddr, pprot, psel, penable, pwrite, pwdata, pauser
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_user,
    output rsp_ready,
    output prdata, pready, pslverr,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  paddr, pprot, psel, penable, pwrite, pwdata, pauser
  );
endinterface

// File: rtl/caliptra_apb_initiator.sv
// SoC-side APB requester for the caliptra_top APB slave port.
// A valid/ready command stream is queued in a small FIFO. Each command is then
// issued as one SETUP + ACCESS transfer. The result is held in a response
// register until the host consumes it. A slave that never raises pready, and a
// command whose address is not word aligned, both return an error response
// instead of stalling the host.
module caliptra_apb_initiator #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int USER_W         = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  caliptra_apb_initiator_if.master bus,
  output logic                     busy
);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Command storage. It holds data only, so it needs no reset.
  logic              write_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] wdata_mem [FIFO_DEPTH];
  logic [USER_W-1:0] user_mem  [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic              req_ready_reg;
  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              psel_reg, penable_reg, pwrite_reg;
  logic [ADDR_W-1:0] paddr_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic [USER_W-1:0] pauser_reg;
  logic              rsp_valid_reg, rsp_err_reg, rsp_timeout_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  logic              push, pop, empty, full_next;
  logic              rsp_free, start, misaligned, done;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [USER_W-1:0] head_user;

  assign head_write = write_mem[rd_ptr_reg[IDX_W-1:0]];
  assign head_addr  = addr_mem[rd_ptr_reg[IDX_W-1:0]];
  assign head_wdata = wdata_mem[rd_ptr_reg[IDX_W-1:0]];
  assign head_user  = user_mem[rd_ptr_reg[IDX_W-1:0]];

  assign push       = bus.req_valid && req_ready_reg;
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign rsp_free   = !rsp_valid_reg || bus.rsp_ready;
  assign start      = (state_reg == IDLE) && !empty && rsp_free;
  assign misaligned = (head_addr[1:0] != 2'b00);
  assign done       = (state_reg == ACCESS) &&
                      (bus.pready || (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)));
  assign pop        = (start && misaligned) || done;

  assign wr_ptr_next = wr_ptr_reg + PTR_W'(push);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
  assign full_next   = (wr_ptr_next[PTR_W-1] != rd_ptr_next[PTR_W-1]) &&
                       (wr_ptr_next[IDX_W-1:0] == rd_ptr_next[IDX_W-1:0]);

  // Write the accepted command into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      write_mem[wr_ptr_reg[IDX_W-1:0]] <= bus.req_write;
      addr_mem[wr_ptr_reg[IDX_W-1:0]]  <= bus.req_addr;
      wdata_mem[wr_ptr_reg[IDX_W-1:0]] <= bus.req_wdata;
      user_mem[wr_ptr_reg[IDX_W-1:0]]  <= bus.req_user;
    end
  end

  // Advance the FIFO pointers. req_ready is registered, so a slot freed by a
  // pop can only be reused in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      req_ready_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      req_ready_reg <= !full_next;
    end
  end

  // Transfer FSM with registered APB outputs and the response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pauser_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      if (rsp_valid_reg && bus.rsp_ready) begin
        rsp_valid_reg   <= 1'b0;
        rsp_rdata_reg   <= '0;
        rsp_err_reg     <= 1'b0;
        rsp_timeout_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (misaligned) begin
              // Reject without touching the bus.
              rsp_valid_reg   <= 1'b1;
              rsp_rdata_reg   <= '0;
              rsp_err_reg     <= 1'b1;
              rsp_timeout_reg <= 1'b0;
            end else begin
              state_reg  <= SETUP;
              psel_reg   <= 1'b1;
              paddr_reg  <= head_addr;
              pwrite_reg <= head_write;
              pwdata_reg <= head_write ? head_wdata : '0;
              pauser_reg <= head_user;
            end
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          cnt_reg     <= '0;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            state_reg     <= RESP;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pauser_reg    <= '0;
            rsp_valid_reg <= 1'b1;
            if (bus.pready) begin
              rsp_rdata_reg   <= (!pwrite_reg && !bus.pslverr) ? bus.prdata : '0;
              rsp_err_reg     <= bus.pslverr;
              rsp_timeout_reg <= 1'b0;
            end else begin
              rsp_rdata_reg   <= '0;
              rsp_err_reg     <= 1'b1;
              rsp_timeout_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;
  assign bus.paddr       = paddr_reg;
  assign bus.pprot       = 3'b000;
  assign bus.psel        = psel_reg;
  assign bus.penable     = penable_reg;
  assign bus.pwrite      = pwrite_reg;
  assign bus.pwdata      = pwdata_reg;
  assign bus.pauser      = pauser_reg;
  assign busy            = !empty || (state_reg != IDLE) || rsp_valid_reg;
endmodule
